// File: rtl/otter_mem_pkg.sv
// Shared types and address-split width helpers for the OTTER memory-side blocks.
// Widths assume 32-bit byte addresses with word-aligned fetches.
package otter_mem_pkg;

   typedef enum logic [1:0] {IDLE, FILL, DONE} icache_state_t;

   function automatic int offset_w(input int words_per_line);
      return $clog2(words_per_line);
   endfunction

   function automatic int index_w(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int tag_w(input int lines, input int words_per_line);
      return 30 - offset_w(words_per_line) - index_w(lines);
   endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational lookup, synchronous word/tag writes.
// Invalidate-all takes priority over a same-cycle valid set.
module icache_array
   import otter_mem_pkg::*;
#(
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic [index_w(LINES)-1:0]                rd_index,
   input  logic [offset_w(WORDS_PER_LINE)-1:0]      rd_offset,
   input  logic [tag_w(LINES, WORDS_PER_LINE)-1:0]  rd_tag,
   output logic                                     hit,
   output logic [31:0]                              rd_data,
   input  logic [index_w(LINES)-1:0]                wr_index,
   input  logic [offset_w(WORDS_PER_LINE)-1:0]      wr_offset,
   input  logic                                     word_wr,
   input  logic [31:0]                              wr_data,
   input  logic                                     tag_wr,
   input  logic [tag_w(LINES, WORDS_PER_LINE)-1:0]  wr_tag,
   input  logic                                     inval_all
);

   localparam int TW = tag_w(LINES, WORDS_PER_LINE);

   logic [LINES-1:0] valid;
   logic [TW-1:0]    tag_mem  [LINES];
   logic [31:0]      data_mem [LINES][WORDS_PER_LINE];

   assign hit     = valid[rd_index] && (tag_mem[rd_index] == rd_tag);
   assign rd_data = data_mem[rd_index][rd_offset];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (inval_all) begin
         valid <= '0;
      end else if (tag_wr) begin
         valid[wr_index] <= 1'b1;
      end
   end

   // Payload storage carries no reset; the valid bits alone qualify it.
   always_ff @(posedge clk) begin
      if (tag_wr) begin
         tag_mem[wr_index] <= wr_tag;
      end
      if (word_wr) begin
         data_mem[wr_index][wr_offset] <= wr_data;
      end
   end

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only I-cache for the OTTER fetch port: hits return same cycle,
// misses hold PC_STALL while a line refill runs word by word against main memory.
module icache_responder
   import otter_mem_pkg::*;
#(
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        MEM_RDEN1,
   input  logic [31:0] MEM_ADDR1,
   output logic [31:0] MEM_DOUT1,
   output logic        PC_STALL,
   input  logic        INVAL,
   output logic        MM_REQ,
   output logic [31:0] MM_ADDR,
   input  logic        MM_ACK,
   input  logic [31:0] MM_RDATA
);

   localparam int OW = offset_w(WORDS_PER_LINE);
   localparam int IW = index_w(LINES);
   localparam int TW = tag_w(LINES, WORDS_PER_LINE);

   logic [OW-1:0] offset;
   logic [IW-1:0] index;
   logic [TW-1:0] tag;
   logic          unused_addr_bits;

   assign offset           = MEM_ADDR1[OW+1:2];
   assign index            = MEM_ADDR1[OW+2 +: IW];
   assign tag              = MEM_ADDR1[31 -: TW];
   assign unused_addr_bits = ^MEM_ADDR1[1:0];

   icache_state_t state, state_nxt;
   logic [TW-1:0] fill_tag;
   logic [IW-1:0] fill_index;
   logic [OW-1:0] cnt;
   logic          kill;
   logic          hit;
   logic          start;
   logic          word_wr;
   logic          tag_wr;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state      <= IDLE;
         cnt        <= '0;
         kill       <= 1'b0;
         fill_tag   <= '0;
         fill_index <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            fill_tag   <= tag;
            fill_index <= index;
            cnt        <= '0;
            kill       <= 1'b0;
         end else if (word_wr) begin
            cnt <= cnt + OW'(1);
         end
         // An invalidate seen mid-refill must keep the in-flight line from becoming valid.
         if (INVAL && state != IDLE) begin
            kill <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      word_wr   = 1'b0;
      tag_wr    = 1'b0;
      MM_REQ    = 1'b0;
      PC_STALL  = 1'b1;
      case (state)
         IDLE: begin
            PC_STALL = MEM_RDEN1 & ~hit;
            if (MEM_RDEN1 && !hit && !INVAL) begin
               start     = 1'b1;
               state_nxt = FILL;
            end
         end
         FILL: begin
            MM_REQ = 1'b1;
            if (MM_ACK) begin
               word_wr = 1'b1;
               if (&cnt) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            tag_wr    = ~kill & ~INVAL;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // {tag,index,cnt,00} is fill_base + 4*cnt since the offset field of fill_base is zero.
   assign MM_ADDR = MM_REQ ? {fill_tag, fill_index, cnt, 2'b00} : 32'h0;

   icache_array #(
      .LINES          (LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE)
   ) u_array (
      .clk       (CLK),
      .rst_n     (RST_N),
      .rd_index  (index),
      .rd_offset (offset),
      .rd_tag    (tag),
      .hit       (hit),
      .rd_data   (MEM_DOUT1),
      .wr_index  (fill_index),
      .wr_offset (cnt),
      .word_wr   (word_wr),
      .wr_data   (MM_RDATA),
      .tag_wr    (tag_wr),
      .wr_tag    (fill_tag),
      .inval_all (INVAL)
   );

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder with a line-level reference cache model
// and a main-memory responder whose word n holds 0x1000_0000+n.
module tb_icache_responder;

   localparam int LINES = 16;
   localparam int WPL   = 4;
   localparam int LINE_BYTES = WPL * 4;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        MEM_RDEN1;
   logic [31:0] MEM_ADDR1;
   logic [31:0] MEM_DOUT1;
   logic        PC_STALL;
   logic        INVAL;
   logic        MM_REQ;
   logic [31:0] MM_ADDR;
   logic        MM_ACK;
   logic [31:0] MM_RDATA;

   int checks = 0;
   int errors = 0;
   int wait_cycles = 0;
   logic [31:0] mm_log[$];

   bit          ref_valid [LINES];
   logic [31:0] ref_base  [LINES];

   always #5 CLK = ~CLK;

   icache_responder #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .MEM_RDEN1 (MEM_RDEN1),
      .MEM_ADDR1 (MEM_ADDR1),
      .MEM_DOUT1 (MEM_DOUT1),
      .PC_STALL  (PC_STALL),
      .INVAL     (INVAL),
      .MM_REQ    (MM_REQ),
      .MM_ADDR   (MM_ADDR),
      .MM_ACK    (MM_ACK),
      .MM_RDATA  (MM_RDATA)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h1000_0000 + (a >> 2);
   endfunction

   function automatic logic [31:0] base_of(input logic [31:0] a);
      return (a / LINE_BYTES) * LINE_BYTES;
   endfunction

   function automatic int line_of(input logic [31:0] a);
      return int'((a / LINE_BYTES) % LINES);
   endfunction

   function automatic bit ref_hit(input logic [31:0] a);
      return ref_valid[line_of(a)] && (ref_base[line_of(a)] == base_of(a));
   endfunction

   task automatic ref_fill(input logic [31:0] a);
      ref_valid[line_of(a)] = 1'b1;
      ref_base[line_of(a)]  = base_of(a);
   endtask

   task automatic ref_clear();
      for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
   endtask

   // Main-memory responder: ACK after wait_cycles idle cycles of a held request.
   initial begin : mm_model
      int wc;
      wc = 0;
      MM_ACK = 1'b0;
      MM_RDATA = 32'h0;
      forever begin
         @(negedge CLK);
         if (MM_REQ === 1'b1) begin
            if (wc >= wait_cycles) begin
               MM_ACK = 1'b1;
               MM_RDATA = mem_word(MM_ADDR);
               mm_log.push_back(MM_ADDR);
               wc = 0;
            end else begin
               MM_ACK = 1'b0;
               MM_RDATA = 32'hDEAD_BEEF;
               wc++;
            end
         end else begin
            MM_ACK = 1'b0;
            wc = 0;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // One fetch from a negedge until PC_STALL drops; checks stall length, data and refill addresses.
   task automatic run_fetch(input logic [31:0] a, input string name);
      bit hit_exp;
      int exp_stall;
      int stall;
      hit_exp = ref_hit(a);
      exp_stall = hit_exp ? 0 : WPL * (wait_cycles + 1) + 2;
      @(negedge CLK);
      mm_log.delete();
      MEM_RDEN1 = 1'b1;
      MEM_ADDR1 = a;
      #1;
      stall = 0;
      while (PC_STALL === 1'b1 && stall < 300) begin
         stall++;
         @(negedge CLK);
         #1;
      end
      checks++;
      if (stall != exp_stall)
         $display("FAIL %s stall_cycles addr=%h: got %0d expected %0d", name, a, stall, exp_stall);
      if (stall != exp_stall) errors++;
      checks++;
      if (MEM_DOUT1 !== mem_word(a)) begin
         $display("FAIL %s dout addr=%h: got %h expected %h", name, a, MEM_DOUT1, mem_word(a));
         errors++;
      end
      if (hit_exp) begin
         checks++;
         if (MM_REQ !== 1'b0 || mm_log.size() != 0) begin
            $display("FAIL %s hit_no_mm addr=%h: got req=%b reads=%0d expected req=0 reads=0",
                     name, a, MM_REQ, mm_log.size());
            errors++;
         end
      end else begin
         checks++;
         if (mm_log.size() != WPL) begin
            $display("FAIL %s mm_count addr=%h: got %0d expected %0d", name, a, mm_log.size(), WPL);
            errors++;
         end
         for (int i = 0; i < WPL && i < mm_log.size(); i++) begin
            checks++;
            if (mm_log[i] !== base_of(a) + 32'(4 * i)) begin
               $display("FAIL %s mm_addr[%0d]: got %h expected %h", name, i, mm_log[i], base_of(a) + 32'(4 * i));
               errors++;
            end
         end
         ref_fill(a);
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      MEM_RDEN1 = 1'b0;
      MEM_ADDR1 = 32'h0;
      INVAL = 1'b0;
      repeat (3) @(negedge CLK);
      #1;
      checks++;
      if (PC_STALL !== 1'b0 || MM_REQ !== 1'b0 || MM_ADDR !== 32'h0) begin
         $display("FAIL reset_idle: got stall=%b req=%b addr=%h expected 0 0 0", PC_STALL, MM_REQ, MM_ADDR);
         errors++;
      end
      MEM_RDEN1 = 1'b1;
      #1;
      checks++;
      if (PC_STALL !== 1'b1) begin
         $display("FAIL reset_stall_rden: got %b expected 1", PC_STALL);
         errors++;
      end
      @(negedge CLK);
      RST_N = 1'b1;
      MEM_RDEN1 = 1'b0;
      ref_clear();
   endtask

   task automatic test_cold_miss();
      wait_cycles = 0;
      run_fetch(32'h0, "cold_miss");
   endtask

   task automatic test_line_hits();
      run_fetch(32'h4, "hit_word1");
      run_fetch(32'h8, "hit_word2");
      run_fetch(32'hC, "hit_word3");
   endtask

   task automatic test_conflict();
      run_fetch(32'h100, "conflict_a");
      run_fetch(32'h0, "conflict_b");
   endtask

   task automatic test_redirect();
      int stall;
      int first_done;
      logic [31:0] exp_addr;
      wait_cycles = 2;
      @(negedge CLK);
      mm_log.delete();
      MEM_RDEN1 = 1'b1;
      MEM_ADDR1 = 32'h20;
      #1;
      stall = 0;
      first_done = -1;
      while (PC_STALL === 1'b1 && stall < 300) begin
         stall++;
         if (first_done < 0 && mm_log.size() == WPL && MM_REQ === 1'b0) first_done = stall;
         if (stall == 4) MEM_ADDR1 = 32'h40;
         @(negedge CLK);
         #1;
      end
      checks++;
      if (first_done != 4 * 3 + 2) begin
         $display("FAIL redirect_first_fill_stall: got %0d expected %0d", first_done, 4 * 3 + 2);
         errors++;
      end
      checks++;
      if (stall != 2 * (4 * 3 + 2)) begin
         $display("FAIL redirect_total_stall: got %0d expected %0d", stall, 2 * (4 * 3 + 2));
         errors++;
      end
      checks++;
      if (mm_log.size() != 2 * WPL) begin
         $display("FAIL redirect_mm_count: got %0d expected %0d", mm_log.size(), 2 * WPL);
         errors++;
      end
      for (int i = 0; i < 2 * WPL && i < mm_log.size(); i++) begin
         exp_addr = (i < WPL) ? 32'h20 + 32'(4 * i) : 32'h40 + 32'(4 * (i - WPL));
         checks++;
         if (mm_log[i] !== exp_addr) begin
            $display("FAIL redirect_mm_addr[%0d]: got %h expected %h", i, mm_log[i], exp_addr);
            errors++;
         end
      end
      checks++;
      if (MEM_DOUT1 !== mem_word(32'h40)) begin
         $display("FAIL redirect_dout: got %h expected %h", MEM_DOUT1, mem_word(32'h40));
         errors++;
      end
      ref_fill(32'h20);
      ref_fill(32'h40);
      run_fetch(32'h20, "redirect_old_hits");
   endtask

   task automatic test_inval();
      int stall;
      wait_cycles = 0;
      run_fetch(32'h100, "inval_evict");
      @(negedge CLK);
      mm_log.delete();
      MEM_RDEN1 = 1'b1;
      MEM_ADDR1 = 32'h0;
      #1;
      stall = 0;
      while (PC_STALL === 1'b1 && stall < 300) begin
         stall++;
         if (stall == 2) INVAL = 1'b1;
         if (stall == 3) INVAL = 1'b0;
         @(negedge CLK);
         #1;
      end
      INVAL = 1'b0;
      // The killed refill leaves line 0 invalid, so the still-pending fetch refills again.
      checks++;
      if (stall != 2 * (WPL + 2)) begin
         $display("FAIL inval_stall: got %0d expected %0d", stall, 2 * (WPL + 2));
         errors++;
      end
      checks++;
      if (mm_log.size() != 2 * WPL) begin
         $display("FAIL inval_mm_count: got %0d expected %0d", mm_log.size(), 2 * WPL);
         errors++;
      end
      for (int i = 0; i < 2 * WPL && i < mm_log.size(); i++) begin
         checks++;
         if (mm_log[i] !== 32'(4 * (i % WPL))) begin
            $display("FAIL inval_mm_addr[%0d]: got %h expected %h", i, mm_log[i], 32'(4 * (i % WPL)));
            errors++;
         end
      end
      checks++;
      if (MEM_DOUT1 !== mem_word(32'h0)) begin
         $display("FAIL inval_dout: got %h expected %h", MEM_DOUT1, mem_word(32'h0));
         errors++;
      end
      ref_clear();
      ref_fill(32'h0);
      run_fetch(32'h40, "inval_old_line_misses");
      run_fetch(32'h0, "inval_refilled_hits");
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int n = 0; n < 40; n++) begin
         wait_cycles = int'($urandom_range(0, 2));
         a = 32'($urandom_range(0, 255)) * 4;
         if ($urandom_range(0, 3) == 0) begin
            @(negedge CLK);
            MEM_RDEN1 = 1'b0;
            MEM_ADDR1 = 32'($urandom_range(0, 255)) * 4;
            #1;
            checks++;
            if (PC_STALL !== 1'b0 || MM_REQ !== 1'b0) begin
               $display("FAIL random_idle: got stall=%b req=%b expected 0 0", PC_STALL, MM_REQ);
               errors++;
            end
         end
         run_fetch(a, "random");
      end
   endtask

   task automatic test_reset_mid_fill();
      int stall;
      wait_cycles = 0;
      @(negedge CLK);
      MEM_RDEN1 = 1'b0;
      INVAL = 1'b1;
      @(negedge CLK);
      INVAL = 1'b0;
      ref_clear();
      MEM_RDEN1 = 1'b1;
      MEM_ADDR1 = 32'h0;
      repeat (3) @(negedge CLK);
      #1;
      checks++;
      if (MM_REQ !== 1'b1 || MM_ADDR !== 32'h8) begin
         $display("FAIL rst_fill_cnt2: got req=%b addr=%h expected 1 00000008", MM_REQ, MM_ADDR);
         errors++;
      end
      RST_N = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      #1;
      checks++;
      if (MM_REQ !== 1'b0 || MM_ADDR !== 32'h0 || PC_STALL !== 1'b1) begin
         $display("FAIL rst_fill_after: got req=%b addr=%h stall=%b expected 0 00000000 1",
                  MM_REQ, MM_ADDR, PC_STALL);
         errors++;
      end
      mm_log.delete();
      stall = 0;
      while (PC_STALL === 1'b1 && stall < 300) begin
         stall++;
         @(negedge CLK);
         #1;
      end
      checks++;
      if (stall != WPL + 2) begin
         $display("FAIL rst_refill_stall: got %0d expected %0d", stall, WPL + 2);
         errors++;
      end
      checks++;
      if (mm_log.size() == 0 || mm_log[0] !== 32'h0) begin
         $display("FAIL rst_refill_first_addr: got count=%0d expected first address 00000000", mm_log.size());
         errors++;
      end
      checks++;
      if (MEM_DOUT1 !== mem_word(32'h0)) begin
         $display("FAIL rst_refill_dout: got %h expected %h", MEM_DOUT1, mem_word(32'h0));
         errors++;
      end
      ref_fill(32'h0);
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_line_hits();
      test_conflict();
      test_redirect();
      test_inval();
      test_random();
      test_reset_mid_fill();
      @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
